// File: rtl/buff2mac.sv
// rtl/buff2mac.sv - packet buffer reader streaming committed frames to the 10G MAC TX client
// Drains {hdr, data...} frames between committed_cons and committed_prod and releases their space.
`ifndef BF
`define BF 9
`endif

module buff2mac #(
   parameter logic [15:0] MIN_LEN = 16'd14,
   parameter logic [15:0] MAX_LEN = 16'd1522
) (
   input  logic          clk,
   input  logic          rst,
   output logic [`BF:0]  rd_addr,
   input  logic [63:0]   rd_data,
   input  logic [`BF:0]  committed_prod,
   output logic [`BF:0]  committed_cons,
   output logic [63:0]   mac_tx_data,
   output logic [7:0]    mac_tx_data_valid,
   output logic          mac_tx_start,
   input  logic          mac_tx_ack,
   output logic          activity,
   output logic [15:0]   sent_pkts,
   output logic [15:0]   bad_hdr
);

   localparam int AW = `BF + 1;
   localparam int NW = 13;

   typedef enum logic [2:0] {IDLE, HDR, PREF, START, STRM, COMMIT, FLUSH} state_t;

   state_t          state;
   logic [AW-1:0]   hdr_addr;
   logic            hdr_ready;
   logic [NW-1:0]   nwords;
   logic [NW-1:0]   wcnt;
   logic [7:0]      last_mask;
   logic [1:0]      pref_cnt;
   logic [63:0]     pref0;
   logic [63:0]     pref1;

   logic [15:0]     hdr_len;
   logic [15:0]     len_p7;
   logic [NW-1:0]   nw_calc;
   logic [7:0]      mask_calc;
   logic [AW-1:0]   cons_next;

   assign hdr_len   = rd_data[47:32];
   assign len_p7    = hdr_len + 16'd7;
   assign nw_calc   = NW'(len_p7 >> 3);
   assign mask_calc = (hdr_len[2:0] == 3'd0) ? 8'hFF : ((8'h01 << hdr_len[2:0]) - 8'h01);
   assign cons_next = hdr_addr + AW'(nwords) + AW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         rd_addr           <= '0;
         committed_cons    <= '0;
         mac_tx_data       <= '0;
         mac_tx_data_valid <= '0;
         mac_tx_start      <= 1'b0;
         activity          <= 1'b0;
         sent_pkts         <= '0;
         bad_hdr           <= '0;
         hdr_addr          <= '0;
         hdr_ready         <= 1'b0;
         nwords            <= '0;
         wcnt              <= '0;
         last_mask         <= '0;
         pref_cnt          <= '0;
         pref0             <= '0;
         pref1             <= '0;
      end else begin
         activity <= 1'b0;
         case (state)
            IDLE: begin
               // rd_addr parks on the next header so its word is already on rd_data when a frame appears
               rd_addr  <= committed_cons;
               hdr_addr <= committed_cons;
               if (committed_prod != committed_cons) begin
                  hdr_ready <= (rd_addr == committed_cons);
                  state     <= HDR;
               end
            end
            HDR: begin
               if (!hdr_ready) begin
                  hdr_ready <= 1'b1;
               end else if (hdr_len < MIN_LEN || hdr_len > MAX_LEN) begin
                  state <= FLUSH;
               end else begin
                  nwords    <= nw_calc;
                  last_mask <= mask_calc;
                  rd_addr   <= rd_addr + AW'(1);
                  pref_cnt  <= '0;
                  state     <= PREF;
               end
            end
            PREF: begin
               pref_cnt <= pref_cnt + 2'd1;
               case (pref_cnt)
                  2'd0: rd_addr <= rd_addr + AW'(1);
                  2'd1: begin
                     rd_addr <= rd_addr + AW'(1);
                     pref0   <= rd_data;
                  end
                  default: begin
                     // rd_addr now parked on word 2, so rd_data holds it steadily while waiting for ack
                     pref1             <= rd_data;
                     mac_tx_data       <= pref0;
                     mac_tx_data_valid <= 8'hFF;
                     mac_tx_start      <= 1'b1;
                     state             <= START;
                  end
               endcase
            end
            START: begin
               if (mac_tx_ack) begin
                  mac_tx_start      <= 1'b0;
                  mac_tx_data       <= pref1;
                  mac_tx_data_valid <= (nwords == NW'(2)) ? last_mask : 8'hFF;
                  rd_addr           <= rd_addr + AW'(1);
                  wcnt              <= NW'(1);
                  activity          <= 1'b1;
                  state             <= STRM;
               end
            end
            STRM: begin
               activity <= 1'b1;
               if (wcnt == nwords - NW'(1)) begin
                  mac_tx_data       <= '0;
                  mac_tx_data_valid <= '0;
                  state             <= COMMIT;
               end else begin
                  mac_tx_data       <= rd_data;
                  mac_tx_data_valid <= (wcnt + NW'(2) == nwords) ? last_mask : 8'hFF;
                  wcnt              <= wcnt + NW'(1);
                  rd_addr           <= rd_addr + AW'(1);
               end
            end
            COMMIT: begin
               committed_cons <= cons_next;
               rd_addr        <= cons_next;
               sent_pkts      <= sent_pkts + 16'd1;
               state          <= IDLE;
            end
            FLUSH: begin
               committed_cons <= committed_prod;
               rd_addr        <= committed_prod;
               bad_hdr        <= bad_hdr + 16'd1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_buff2mac.sv
// tb/tb_buff2mac.sv - randomized self-checking bench for buff2mac against a frame-level model
`ifndef BF
`define BF 9
`endif

module tb_buff2mac;

   localparam int AW    = `BF + 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rd_addr;
   logic [63:0]   rd_data = '0;
   logic [AW-1:0] committed_prod = '0;
   logic [AW-1:0] committed_cons;
   logic [63:0]   mac_tx_data;
   logic [7:0]    mac_tx_data_valid;
   logic          mac_tx_start;
   logic          mac_tx_ack = 1'b0;
   logic          activity;
   logic [15:0]   sent_pkts;
   logic [15:0]   bad_hdr;

   logic [63:0]   mem [DEPTH];
   int            n_checks = 0;
   int            n_errors = 0;
   logic [AW-1:0] cons_m;
   int            sent_m;
   int            bad_m;

   buff2mac dut (
      .clk               (clk),
      .rst               (rst),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .committed_prod    (committed_prod),
      .committed_cons    (committed_cons),
      .mac_tx_data       (mac_tx_data),
      .mac_tx_data_valid (mac_tx_data_valid),
      .mac_tx_start      (mac_tx_start),
      .mac_tx_ack        (mac_tx_ack),
      .activity          (activity),
      .sent_pkts         (sent_pkts),
      .bad_hdr           (bad_hdr)
   );

   always #5 clk = ~clk;

   // one-cycle read latency buffer
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int nwords_of(input int len);
      return (len + 7) / 8;
   endfunction

   function automatic logic [7:0] mask_of(input int len);
      int b;
      b = len - 8 * (nwords_of(len) - 1);
      return 8'((1 << b) - 1);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, "_cons"}, 64'(committed_cons), 64'd0);
      check({tag, "_data"}, mac_tx_data, 64'd0);
      check({tag, "_valid"}, 64'(mac_tx_data_valid), 64'd0);
      check({tag, "_start"}, 64'(mac_tx_start), 64'd0);
      check({tag, "_activity"}, 64'(activity), 64'd0);
      check({tag, "_sent"}, 64'(sent_pkts), 64'd0);
      check({tag, "_bad"}, 64'(bad_hdr), 64'd0);
   endtask

   task automatic put_frame(input logic [AW-1:0] h, input int len, output logic [AW-1:0] nxt);
      logic [AW-1:0] a;
      mem[h] = {16'h0, 16'(len), 32'h0};
      for (int k = 0; k < nwords_of(len); k++) begin
         a = h + AW'(1 + k);
         mem[a] = {$urandom, $urandom};
      end
      nxt = h + AW'(1 + nwords_of(len));
   endtask

   task automatic bad_frame(input int len, input logic [AW-1:0] target);
      int starts;
      starts = 0;
      mem[cons_m] = {16'h0, 16'(len), 32'h0};
      committed_prod = target;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mac_tx_start) starts++;
      end
      bad_m++;
      cons_m = target;
      check("flush_no_start", 64'(starts), 64'd0);
      check("flush_cons", 64'(committed_cons), 64'(cons_m));
      check("flush_bad_hdr", 64'(bad_hdr), 64'(16'(bad_m)));
   endtask

   task automatic run_frame(input logic [AW-1:0] h, input int len, input int ack_dly,
                            input bit chk_lat, input int rst_at);
      int          n;
      int          lat;
      int          unstable;
      int          act;
      logic [63:0] w [$];
      n = nwords_of(len);
      lat = 0;
      unstable = 0;
      act = 0;
      for (int k = 0; k < n; k++) w.push_back(mem[h + AW'(1 + k)]);
      while (!mac_tx_start && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("start_timeout", 64'(mac_tx_start), 64'd1);
      if (!mac_tx_start) return;
      if (chk_lat) check("start_latency_le5", 64'(lat <= 5), 64'd1);
      for (int d = 0; d < ack_dly; d++) begin
         if (mac_tx_start !== 1'b1 || mac_tx_data !== w[0] || mac_tx_data_valid !== 8'hFF)
            unstable++;
         @(negedge clk);
      end
      check("start_hold_stable", 64'(unstable), 64'd0);
      check("word0", mac_tx_data, w[0]);
      check("word0_valid", 64'(mac_tx_data_valid), 64'hFF);
      mac_tx_ack = 1'b1;
      if (activity) act++;
      @(negedge clk);
      mac_tx_ack = 1'b0;
      check("start_drop", 64'(mac_tx_start), 64'd0);
      for (int k = 1; k < n; k++) begin
         if (activity) act++;
         check($sformatf("word%0d", k), mac_tx_data, w[k]);
         check($sformatf("valid%0d", k), 64'(mac_tx_data_valid),
               64'((k == n - 1) ? mask_of(len) : 8'hFF));
         if (k == rst_at) begin
            rst = 1'b1;
            committed_prod = '0;
            @(negedge clk);
            check_reset_outputs("midframe_rst");
            rst = 1'b0;
            cons_m = '0;
            sent_m = 0;
            bad_m = 0;
            return;
         end
         @(negedge clk);
      end
      if (activity) act++;
      check("gap_valid", 64'(mac_tx_data_valid), 64'd0);
      @(negedge clk);
      cons_m = h + AW'(1 + n);
      sent_m++;
      check("activity_pulses", 64'(act), 64'(n));
      check("cons_after_frame", 64'(committed_cons), 64'(cons_m));
      check("sent_pkts", 64'(sent_pkts), 64'(16'(sent_m)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] nxt;
      logic [AW-1:0] nxt2;
      logic [AW-1:0] h;
      int            moved;
      int            len2;
      int            bl;
      int            gl;
      int            span;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      cons_m = '0;
      sent_m = 0;
      bad_m = 0;

      // reset and empty buffer
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      moved = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mac_tx_start || rd_addr != '0) moved++;
      end
      check("empty_idle_quiet", 64'(moved), 64'd0);

      // full-word frame, delayed ack
      put_frame(cons_m, 64, nxt);
      committed_prod = nxt;
      run_frame(cons_m, 64, 3, 1'b1, -1);

      // partial last word and minimum length
      put_frame(cons_m, 61, nxt);
      committed_prod = nxt;
      run_frame(cons_m, 61, 1, 1'b1, -1);
      put_frame(cons_m, 14, nxt);
      committed_prod = nxt;
      run_frame(cons_m, 14, 0, 1'b1, -1);

      // move to the top of the buffer, then two back-to-back frames across the wrap
      bad_frame(0, AW'(DEPTH - 2));
      h = AW'(DEPTH - 2);
      len2 = $urandom_range(14, 200);
      put_frame(h, 60, nxt);
      put_frame(nxt, len2, nxt2);
      committed_prod = nxt2;
      run_frame(h, 60, 2, 1'b1, -1);
      run_frame(nxt, len2, 0, 1'b0, -1);

      // long ack stall then reset in the middle of streaming
      put_frame(cons_m, 200, nxt);
      committed_prod = nxt;
      run_frame(cons_m, 200, 20, 1'b1, 4);
      repeat (2) @(negedge clk);

      // rejected headers
      bad_frame(0, AW'(20));
      bad_frame(2000, AW'(40));

      // randomized mix of good and bad frames
      for (int it = 0; it < 14; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            bl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 13) : $urandom_range(1523, 5000);
            span = $urandom_range(1, 40);
            bad_frame(bl, cons_m + AW'(span));
         end else begin
            gl = $urandom_range(14, 1522);
            put_frame(cons_m, gl, nxt);
            committed_prod = nxt;
            run_frame(cons_m, gl, $urandom_range(0, 6), 1'b1, -1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
